multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control unit for the MIPS-lite core: a state machine that sequences the shared datapath (PC, IR, GPR file, ALU, data memory) through fetch, decode, execute, memory and write-back. It replaces per-instruction single-cycle decoding with per-state control, so one ALU and one memory port serve every phase. It supports addu, subu, ori, lw, sw, beq, lui, jal and jr. It reads opcode/funct from the datapath's IR and the ALU zero flag, and drives every write enable and mux select.

## Interface
- No parameters; encodings are fixed constants (see Structure).
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces the FSM to FETCH.
- op  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU result == 0, valid in EXE.
- PCWr  out  1  PC write enable.
- PCSrc  out  2  00 ALU PC+4, 01 branch target, 10 jump target, 11 GPR[rs].
- IRWr  out  1  IR write enable.
- RegWrite  out  1  GPR write enable.
- RegDst  out  2  00 rt, 01 rd, 10 $31.
- MemtoReg  out  2  00 ALU out, 01 mem data, 11 PC (already PC+4).
- ALUSrc  out  1  0 GPR[rt], 1 extended imm.
- ExtOp  out  1  0 sign-extend, 1 zero-extend.
- ALUOp  out  3  000 add, 001 sub, 010 or, 011 lui (imm<<16).
- MemWrite  out  1  data memory write enable.
- instr_done  out  1  high in the last cycle of each instruction.
- state  out  3  current state, for debug.

## Operation
- States: FETCH(0), DECODE(1), EXE(2), MEM(3), WB(4); codes 5–7 are illegal and go to FETCH next cycle with all enables low.
- FETCH: IRWr=1, PCWr=1, PCSrc=00. Next state: DECODE.
- DECODE:
  - jal: PCWr=1, PCSrc=10, RegWrite=1, RegDst=10, MemtoReg=11, instr_done=1. Next state: FETCH.
  - jr (op=0, funct=001000): PCWr=1, PCSrc=11, instr_done=1. Next state: FETCH.
  - Unrecognised op/funct: treated as NOP, instr_done=1. Next state: FETCH.
  - Otherwise: next state EXE.
- EXE:
  - R-type: ALUSrc=0; ALUOp from funct (100001→000, 100011→001).
  - ori: ALUSrc=1, ExtOp=1, ALUOp=010.
  - lui: ALUSrc=1, ALUOp=011.
  - lw/sw: ALUSrc=1, ExtOp=0, ALUOp=000.
  - beq: ALUOp=001, PCSrc=01, PCWr=zero, instr_done=1. Next state: FETCH.
  - lw/sw next state: MEM. R/ori/lui next state: WB.
- EXE control values are held stable through MEM/WB for the same instruction, so the datapath needs no ALU-out register timing assumptions.
- MEM:
  - sw: MemWrite=1, instr_done=1. Next state: FETCH.
  - lw: next state WB.
- WB: RegWrite=1.
  - R-type: RegDst=01, MemtoReg=00.
  - ori/lui: RegDst=00, MemtoReg=00.
  - lw: RegDst=00, MemtoReg=01.
  - instr_done=1. Next state: FETCH.
- Every output not listed for a state is 0 in that state.

## Timing
- Outputs are combinational from the registered state plus op/funct/zero; there are no output registers.
- Cycles per instruction: jal/jr/NOP 2, beq 3, sw 4, R/ori/lui 4, lw 5.
- While reset is high: state=FETCH, and PCWr, IRWr, RegWrite, MemWrite and instr_done are forced to 0. Selects take their FETCH values (PCSrc=00, others 0).
- First fetch happens in the first cycle after reset deasserts.
- Reset asserted mid-instruction: the instruction is abandoned immediately; no further write enable pulses for it.
- op/funct must not change except via IRWr in FETCH. The controller latches nothing itself.
- beq with zero=0: PCWr stays 0, and the PC keeps the PC+4 value written in FETCH.

## Structure
- Shared package mips_defs holds:
  - state codes
  - opcode constants (R=000000, lw=100011, sw=101011, beq=000100, lui=001111, ori=001101, jal=000011)
  - funct constants (addu, subu, jr)
  - ALUOp, PCSrc, RegDst and MemtoReg encodings
- Sub-module instr_class: combinational op/funct → one-hot {rtype, addu, subu, jr, ori, lui, lw, sw, beq, jal, nop}. The FSM consumes only these class bits.

## Test plan
- Reset: hold reset 3 cycles, then release → state=0, all enables 0 during reset. Cycle after release: IRWr=1, PCWr=1.
- lw (op=100011): state sequence 0,1,2,3,4. ALUSrc=1 in EXE. WB: RegWrite=1, RegDst=00, MemtoReg=01. instr_done only in WB.
- beq: zero=1 → EXE has PCWr=1, PCSrc=01, 3 cycles total. zero=0 → PCWr=0 in EXE.
- subu (funct=100011): ALUOp=001 in EXE. WB: RegDst=01. addu gives ALUOp=000.
- jal then jr: each takes 2 cycles. jal DECODE: PCSrc=10, RegDst=10, MemtoReg=11, RegWrite=1. jr DECODE: PCSrc=11, RegWrite=0.
- Reset asserted in MEM of sw → MemWrite drops in the same cycle, and state returns to 0 asynchronously. Opcode 111111 → treated as NOP, back in FETCH after 2 cycles with no writes.

Source files
------------

// File: rtl/mips_defs.sv
// Shared encodings for the MIPS-lite multi-cycle core: state codes, opcodes,
// funct codes, datapath select encodings and the decoded instruction class.
package mips_defs;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXE    = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_OR  = 3'b010,
    ALU_LUI = 3'b011
  } aluOp_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_REG    = 2'b11
  } pcSrc_e;

  typedef enum logic [1:0] {
    DST_RT = 2'b00,
    DST_RD = 2'b01,
    DST_RA = 2'b10
  } regDst_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC  = 2'b11
  } memtoReg_e;

  // rtype is set together with addu or subu; jr and nop stand alone
  typedef struct packed {
    logic rtype;
    logic addu;
    logic subu;
    logic jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic jal;
    logic nop;
  } instrClass_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and ALU zero in, enables and selects out.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       PCWr;
  logic [1:0] PCSrc;
  logic       IRWr;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       ALUSrc;
  logic       ExtOp;
  logic [2:0] ALUOp;
  logic       MemWrite;
  logic       instr_done;
  logic [2:0] state;

  modport master (
    input  op, funct, zero,
    output PCWr, PCSrc, IRWr, RegWrite, RegDst, MemtoReg,
           ALUSrc, ExtOp, ALUOp, MemWrite, instr_done, state
  );

  modport slave (
    output op, funct, zero,
    input  PCWr, PCSrc, IRWr, RegWrite, RegDst, MemtoReg,
           ALUSrc, ExtOp, ALUOp, MemWrite, instr_done, state
  );
endinterface

// File: rtl/instr_class.sv
// Combinational opcode/funct decode into instruction class bits; anything
// outside the supported set decodes as nop.
module instr_class
  import mips_defs::*;
(
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output instrClass_t cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin cls.rtype = 1'b1; cls.addu = 1'b1; end
          FN_SUBU: begin cls.rtype = 1'b1; cls.subu = 1'b1; end
          FN_JR:   cls.jr = 1'b1;
          default: cls.nop = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: cls.nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-lite core: sequences FETCH, DECODE,
// EXE, MEM and WB and drives every datapath enable and select combinationally.
module multicycle_ctrl
  import mips_defs::*;
(
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);

  instrClass_t cls;
  logic [2:0]  state;
  logic [2:0]  stateNext;
  logic        pcWr;
  pcSrc_e      pcSrc;
  logic        irWr;
  logic        regWrite;
  regDst_e     regDst;
  memtoReg_e   memtoReg;
  logic        aluSrc;
  logic        extOp;
  aluOp_e      aluOp;
  logic        memWrite;
  logic        done;

  instr_class uClass (
    .op    (bus.op),
    .funct (bus.funct),
    .cls   (cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_FETCH;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = ST_FETCH;
    pcWr      = 1'b0;
    pcSrc     = PC_PLUS4;
    irWr      = 1'b0;
    regWrite  = 1'b0;
    regDst    = DST_RT;
    memtoReg  = WB_ALU;
    aluSrc    = 1'b0;
    extOp     = 1'b0;
    aluOp     = ALU_ADD;
    memWrite  = 1'b0;
    done      = 1'b0;

    // ALU controls stay valid from EXE through MEM/WB of the same instruction
    if (state == ST_EXE || state == ST_MEM || state == ST_WB) begin
      if (cls.addu || cls.lw || cls.sw) aluOp = ALU_ADD;
      if (cls.subu || cls.beq)          aluOp = ALU_SUB;
      if (cls.lw || cls.sw)             aluSrc = 1'b1;
      if (cls.ori) begin
        aluOp  = ALU_OR;
        aluSrc = 1'b1;
        extOp  = 1'b1;
      end
      if (cls.lui) begin
        aluOp  = ALU_LUI;
        aluSrc = 1'b1;
      end
    end

    case (state)
      ST_FETCH: begin
        irWr      = 1'b1;
        pcWr      = 1'b1;
        stateNext = ST_DECODE;
      end
      ST_DECODE: begin
        if (cls.jal) begin
          pcWr     = 1'b1;
          pcSrc    = PC_JUMP;
          regWrite = 1'b1;
          regDst   = DST_RA;
          memtoReg = WB_PC;
          done     = 1'b1;
        end else if (cls.jr) begin
          pcWr  = 1'b1;
          pcSrc = PC_REG;
          done  = 1'b1;
        end else if (cls.nop) begin
          done = 1'b1;
        end else begin
          stateNext = ST_EXE;
        end
      end
      ST_EXE: begin
        if (cls.beq) begin
          pcSrc = PC_BRANCH;
          pcWr  = bus.zero;
          done  = 1'b1;
        end else if (cls.lw || cls.sw) begin
          stateNext = ST_MEM;
        end else if (cls.rtype || cls.ori || cls.lui) begin
          stateNext = ST_WB;
        end
      end
      ST_MEM: begin
        if (cls.sw) begin
          memWrite = 1'b1;
          done     = 1'b1;
        end else if (cls.lw) begin
          stateNext = ST_WB;
        end
      end
      ST_WB: begin
        if (cls.rtype || cls.ori || cls.lui || cls.lw) begin
          regWrite = 1'b1;
          regDst   = cls.rtype ? DST_RD : DST_RT;
          memtoReg = cls.lw ? WB_MEM : WB_ALU;
          done     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // state is already FETCH during reset, so only the enables need forcing low
  assign bus.PCWr       = pcWr     & ~reset;
  assign bus.IRWr       = irWr     & ~reset;
  assign bus.RegWrite   = regWrite & ~reset;
  assign bus.MemWrite   = memWrite & ~reset;
  assign bus.instr_done = done     & ~reset;
  assign bus.PCSrc      = pcSrc;
  assign bus.RegDst     = regDst;
  assign bus.MemtoReg   = memtoReg;
  assign bus.ALUSrc     = aluSrc;
  assign bus.ExtOp      = extOp;
  assign bus.ALUOp      = aluOp;
  assign bus.state      = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction expected control words
// are queued at issue time and a negedge monitor compares them cycle by cycle.
module tb_multicycle_ctrl;
  import mips_defs::*;

  typedef struct packed {
    logic [2:0] state;
    logic       pcWr;
    logic [1:0] pcSrc;
    logic       irWr;
    logic       regWrite;
    logic [1:0] regDst;
    logic [1:0] memtoReg;
    logic       aluSrc;
    logic       extOp;
    logic [2:0] aluOp;
    logic       memWrite;
    logic       done;
  } ctrlVec_t;

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4;
  localparam int K_SW = 5, K_BEQ = 6, K_JAL = 7, K_JR = 8, K_NOP = 9;
  string kindName [10] = '{"addu", "subu", "ori", "lui", "lw", "sw", "beq", "jal", "jr", "nop"};

  logic clk = 1'b0;
  logic reset = 1'b1;
  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  ctrlVec_t expQ [$];
  string    nameQ [$];
  int       nCompared = 0;
  int       nMismatched = 0;
  bit       running = 1'b0;

  function automatic ctrlVec_t mk(int st, int pcWr, int pcSrc, int irWr, int regWr, int regDst,
                                  int m2r, int aluSrc, int extOp, int aluOp, int memWr, int done);
    ctrlVec_t v;
    v.state    = st[2:0];
    v.pcWr     = pcWr[0];
    v.pcSrc    = pcSrc[1:0];
    v.irWr     = irWr[0];
    v.regWrite = regWr[0];
    v.regDst   = regDst[1:0];
    v.memtoReg = m2r[1:0];
    v.aluSrc   = aluSrc[0];
    v.extOp    = extOp[0];
    v.aluOp    = aluOp[2:0];
    v.memWrite = memWr[0];
    v.done     = done[0];
    return v;
  endfunction

  function automatic ctrlVec_t sampleDut();
    ctrlVec_t v;
    v.state    = bus.state;
    v.pcWr     = bus.PCWr;
    v.pcSrc    = bus.PCSrc;
    v.irWr     = bus.IRWr;
    v.regWrite = bus.RegWrite;
    v.regDst   = bus.RegDst;
    v.memtoReg = bus.MemtoReg;
    v.aluSrc   = bus.ALUSrc;
    v.extOp    = bus.ExtOp;
    v.aluOp    = bus.ALUOp;
    v.memWrite = bus.MemWrite;
    v.done     = bus.instr_done;
    return v;
  endfunction

  task automatic check(string name, ctrlVec_t act, ctrlVec_t exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: the control word of every cycle an instruction spends in the controller
  task automatic buildRows(input int kind, input logic z, output ctrlVec_t rows [$]);
    ctrlVec_t dec;
    rows = {};
    dec = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rows.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    case (kind)
      K_ADDU: begin
        rows.push_back(dec);
        rows.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
      end
      K_SUBU: begin
        rows.push_back(dec);
        rows.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        rows.push_back(mk(4, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1));
      end
      K_ORI: begin
        rows.push_back(dec);
        rows.push_back(mk(2, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0));
        rows.push_back(mk(4, 0, 0, 0, 1, 0, 0, 1, 1, 2, 0, 1));
      end
      K_LUI: begin
        rows.push_back(dec);
        rows.push_back(mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0));
        rows.push_back(mk(4, 0, 0, 0, 1, 0, 0, 1, 0, 3, 0, 1));
      end
      K_LW: begin
        rows.push_back(dec);
        rows.push_back(mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        rows.push_back(mk(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        rows.push_back(mk(4, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1));
      end
      K_SW: begin
        rows.push_back(dec);
        rows.push_back(mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        rows.push_back(mk(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
      end
      K_BEQ: begin
        rows.push_back(dec);
        rows.push_back(mk(2, int'(z), 1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
      end
      K_JAL: rows.push_back(mk(1, 1, 2, 0, 1, 2, 3, 0, 0, 0, 0, 1));
      K_JR:  rows.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      default: rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    endcase
  endtask

  task automatic pickEncoding(input int kind, output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom_range(0, 63));
    case (kind)
      K_ADDU: begin op = OP_RTYPE; fn = FN_ADDU; end
      K_SUBU: begin op = OP_RTYPE; fn = FN_SUBU; end
      K_JR:   begin op = OP_RTYPE; fn = FN_JR; end
      K_ORI:  op = OP_ORI;
      K_LUI:  op = OP_LUI;
      K_LW:   op = OP_LW;
      K_SW:   op = OP_SW;
      K_BEQ:  op = OP_BEQ;
      K_JAL:  op = OP_JAL;
      default: begin
        if ($urandom_range(0, 1) == 1) begin
          op = OP_RTYPE;
          while (fn inside {FN_ADDU, FN_SUBU, FN_JR}) fn = 6'($urandom_range(0, 63));
        end else begin
          op = 6'($urandom_range(0, 63));
          while (op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_LUI, OP_ORI, OP_JAL})
            op = 6'($urandom_range(0, 63));
        end
      end
    endcase
  endtask

  // Called during the FETCH cycle (#1 after its edge); returns at the next FETCH
  task automatic runRaw(input int kind, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input int keep);
    ctrlVec_t rows [$];
    int n;
    bus.op    = op;
    bus.funct = fn;
    bus.zero  = z;
    buildRows(kind, z, rows);
    n = (rows.size() < keep) ? rows.size() : keep;
    for (int i = 0; i < n; i++) begin
      expQ.push_back(rows[i]);
      nameQ.push_back($sformatf("%s row%0d", kindName[kind], i));
    end
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic runInstr(input int kind, input logic z);
    logic [5:0] op;
    logic [5:0] fn;
    pickEncoding(kind, op, fn);
    runRaw(kind, op, fn, z, 99);
  endtask

  always @(negedge clk) begin
    if (running && !reset) begin
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("FAIL idle @%0t: state %0d with no instruction expected", $time, bus.state);
      end else begin
        check(nameQ.pop_front(), sampleDut(), expQ.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.op    = 6'd0;
    bus.funct = 6'd0;
    bus.zero  = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("during reset", sampleDut(), '0);
    end
    @(posedge clk);
    #1;
    reset   = 1'b0;
    running = 1'b1;

    runInstr(K_LW, 1'b0);
    runInstr(K_BEQ, 1'b1);
    runInstr(K_BEQ, 1'b0);
    runInstr(K_SUBU, 1'b0);
    runInstr(K_ADDU, 1'b1);
    runInstr(K_ORI, 1'b0);
    runInstr(K_LUI, 1'b0);
    runInstr(K_SW, 1'b0);
    runInstr(K_JAL, 1'b0);
    runInstr(K_JR, 1'b0);
    runRaw(K_NOP, 6'b111111, 6'b000000, 1'b0, 99);

    // sw abandoned by reset in MEM: stop after EXE rows, now in MEM
    runRaw(K_SW, OP_SW, 6'd5, 1'b0, 3);
    #2;
    check("sw MEM before reset", sampleDut(), mk(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
    reset = 1'b1;
    #1;
    check("sw reset async", sampleDut(), '0);
    @(posedge clk);
    #1;
    check("reset held", sampleDut(), '0);
    reset = 1'b0;

    runInstr(K_ADDU, 1'b0);
    for (int i = 0; i < 150; i++)
      runInstr(int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));

    running = 1'b0;
    nCompared++;
    if (expQ.size() != 0) begin
      nMismatched++;
      $display("FAIL drain: %0d expected rows never seen, required 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
